sys_bus: RTL and testbench

- Parametrised memory/bus subsystem sitting between the cpu and storage; next generation of the computer-level memory integration.
- Arbitrates an instruction-fetch port and a data port onto one single-port internal RAM using a ready handshake.
- Adds a memory-mapped LED output register.
- The cpu stalls on ready instead of relying on zero-latency dual-port memory.

---
 rtl/sys_bus_if.sv | 31 +++
 rtl/sys_bus.sv | 169 ++++++++++++++++
 tb/tb_sys_bus.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/sys_bus_if.sv
`default_nettype none
// ============================================================================
// sys_bus_if - fetch and data port bundle between the cpu and sys_bus
// Rev 1.0
// ============================================================================
interface sys_bus_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_data;
  logic              i_ready;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ready;

  modport master (
    output i_req, i_addr, d_read, d_write, d_addr, d_wdata,
    input  i_data, i_ready, d_rdata, d_ready
  );

  modport slave (
    input  i_req, i_addr, d_read, d_write, d_addr, d_wdata,
    output i_data, i_ready, d_rdata, d_ready
  );
endinterface
`default_nettype wire

// File: rtl/sys_bus.sv
`default_nettype none
// ============================================================================
// sys_bus - fetch/data arbiter onto one single-port RAM plus an LED register
// Rev 1.0 | optional: SYS_BUS_DPRIO_EN (data port wins every conflict)
// ============================================================================
module sys_bus #(
  parameter int                ADDR_W    = 16,
  parameter int                DATA_W    = 16,
  parameter int                MEM_DEPTH = 1024,
  parameter int                LED_W     = 8,
  parameter logic [ADDR_W-1:0] LED_ADDR  = 16'hFFFF
) (
  input  logic             clk,
  input  logic             rst,
  sys_bus_if.slave         bus,
  output logic [LED_W-1:0] led
);
  localparam int              c_IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_W:0] c_DEPTH = (ADDR_W+1)'(MEM_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    I_ACC = 2'd1,
    D_ACC = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_d_req;
  logic               w_gnt_i;
  logic               w_gnt_d;
  logic               w_pick_i;
  logic               w_acc_en;
  logic               w_ram_we;
  logic               w_i_hit;
  logic               w_d_hit;
  logic               w_d_led;
  logic [c_IDX_W-1:0] w_idx;
  logic [DATA_W-1:0]  w_acc_data;

  logic [DATA_W-1:0]  mem [MEM_DEPTH];
  logic [DATA_W-1:0]  r_ram_q;
  logic               r_hit_ram;
  logic               r_hit_led;
  logic               r_is_wr;
  logic [LED_W-1:0]   r_led;
  logic [DATA_W-1:0]  r_i_hold;
  logic [DATA_W-1:0]  r_d_hold;

  assign w_d_req  = bus.d_read | bus.d_write;
  assign w_i_hit  = {1'b0, bus.i_addr} < c_DEPTH;
  assign w_d_hit  = {1'b0, bus.d_addr} < c_DEPTH;
  assign w_d_led  = bus.d_addr == LED_ADDR;
  assign w_idx    = w_gnt_d ? bus.d_addr[c_IDX_W-1:0] : bus.i_addr[c_IDX_W-1:0];
  assign w_acc_en = (w_gnt_i | w_gnt_d) & ~rst;
  assign w_ram_we = w_gnt_d & bus.d_write & w_d_hit;
  assign led      = r_led;

`ifdef SYS_BUS_DPRIO_EN
  assign w_pick_i = 1'b0;
`else
  logic r_last_i;

  // Conflict goes to the port that did not win the previous grant.
  assign w_pick_i = ~r_last_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_i <= 1'b1;
    end else if (w_gnt_i | w_gnt_d) begin
      r_last_i <= w_gnt_i;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_i     = 1'b0;
    w_gnt_d     = 1'b0;
    bus.i_ready = 1'b0;
    bus.d_ready = 1'b0;
    bus.i_data  = r_i_hold;
    bus.d_rdata = r_d_hold;
    case (r_state)
      IDLE: begin
        if (bus.i_req && w_d_req) begin
          w_gnt_i = w_pick_i;
          w_gnt_d = ~w_pick_i;
        end else begin
          w_gnt_i = bus.i_req;
          w_gnt_d = w_d_req;
        end
        if (w_gnt_i) begin
          w_state_nxt = I_ACC;
        end else if (w_gnt_d) begin
          w_state_nxt = D_ACC;
        end
      end
      I_ACC: begin
        bus.i_ready = 1'b1;
        bus.i_data  = w_acc_data;
        w_state_nxt = IDLE;
      end
      D_ACC: begin
        bus.d_ready = 1'b1;
        bus.d_rdata = w_acc_data;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Read-first single port: the granted address is applied on the grant edge.
  always_ff @(posedge clk) begin
    if (w_acc_en) begin
      if (w_ram_we) begin
        mem[w_idx] <= bus.d_wdata;
      end
      r_ram_q <= mem[w_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hit_ram <= 1'b0;
      r_hit_led <= 1'b0;
      r_is_wr   <= 1'b0;
    end else if (w_acc_en) begin
      r_hit_ram <= w_gnt_d ? w_d_hit : w_i_hit;
      r_hit_led <= w_gnt_d & w_d_led;
      r_is_wr   <= w_gnt_d & bus.d_write;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_led <= '0;
    end else if (w_acc_en && w_gnt_d && bus.d_write && w_d_led) begin
      r_led <= bus.d_wdata[LED_W-1:0];
    end
  end

  assign w_acc_data = r_is_wr   ? '0 :
                      r_hit_ram ? r_ram_q :
                      r_hit_led ? DATA_W'(r_led) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_i_hold <= '0;
      r_d_hold <= '0;
    end else begin
      if (r_state == I_ACC) begin
        r_i_hold <= w_acc_data;
      end
      if (r_state == D_ACC) begin
        r_d_hold <= w_acc_data;
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_sys_bus.sv
`default_nettype none
// ============================================================================
// tb_sys_bus - directed and random accesses checked against a behavioural model
// Rev 1.0
// ============================================================================
module tb_sys_bus;
  logic       clk;
  logic       rst;
  logic [7:0] led;

  int n_checks = 0;
  int n_err    = 0;

  // Behavioural model state
  logic [15:0] mem_m [0:1023];
  logic [7:0]  led_m;
  logic [15:0] i_hold_m;
  logic [15:0] d_hold_m;
  bit          last_i_m;

  sys_bus_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  sys_bus #(
    .ADDR_W   (16),
    .DATA_W   (16),
    .MEM_DEPTH(1024),
    .LED_W    (8),
    .LED_ADDR (16'hFFFF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .led(led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_fetch(input logic [15:0] a);
    return (a < 16'd1024) ? mem_m[a[9:0]] : 16'h0000;
  endfunction

  function automatic logic [15:0] exp_read(input logic [15:0] a);
    if (a < 16'd1024) return mem_m[a[9:0]];
    if (a == 16'hFFFF) return {8'h00, led_m};
    return 16'h0000;
  endfunction

  // kind: 0 fetch, 1 read, 2 write, 3 read+write. Called one step after a
  // rising edge with the bus idle; ready must follow the grant edge directly.
  task automatic access(input int kind, input logic [15:0] a, input logic [15:0] wd, input string tag);
    logic [15:0] e;
    bus.i_req   = (kind == 0);
    bus.d_read  = (kind == 1) || (kind == 3);
    bus.d_write = (kind >= 2);
    bus.i_addr  = a;
    bus.d_addr  = a;
    bus.d_wdata = wd;
    if (kind == 0) e = exp_fetch(a);
    else if (kind == 1) e = exp_read(a);
    else begin
      e = 16'h0000;
      if (a < 16'd1024) mem_m[a[9:0]] = wd;
      else if (a == 16'hFFFF) led_m = wd[7:0];
    end
    @(posedge clk); #1;
    last_i_m = (kind == 0);
    if (kind == 0) begin
      chk({tag, "_i_ready"}, bus.i_ready, 1'b1);
      chk({tag, "_d_ready"}, bus.d_ready, 1'b0);
      chk({tag, "_i_data"}, bus.i_data, e);
      i_hold_m = e;
    end else begin
      chk({tag, "_d_ready"}, bus.d_ready, 1'b1);
      chk({tag, "_i_ready"}, bus.i_ready, 1'b0);
      chk({tag, "_d_rdata"}, bus.d_rdata, e);
      d_hold_m = e;
    end
    bus.i_req   = 1'b0;
    bus.d_read  = 1'b0;
    bus.d_write = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_i_ready_drop"}, bus.i_ready, 1'b0);
    chk({tag, "_d_ready_drop"}, bus.d_ready, 1'b0);
    chk({tag, "_i_hold"}, bus.i_data, i_hold_m);
    chk({tag, "_d_hold"}, bus.d_rdata, d_hold_m);
    chk({tag, "_led"}, led, led_m);
  endtask

  initial begin
    logic [15:0] pool [0:9];
    logic [15:0] a;
    int          k;
    bit          win_i;

    pool = '{16'h0000, 16'h0001, 16'h0010, 16'h0020, 16'h03FF,
             16'h0400, 16'h0401, 16'hFFFF, 16'hFFFE, 16'h8000};
    rst = 1'b1;
    bus.i_req = 1'b0; bus.d_read = 1'b0; bus.d_write = 1'b0;
    bus.i_addr = '0; bus.d_addr = '0; bus.d_wdata = '0;
    led_m = 8'h00; i_hold_m = 16'h0; d_hold_m = 16'h0; last_i_m = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_i_ready", bus.i_ready, 1'b0);
    chk("rst_d_ready", bus.d_ready, 1'b0);
    chk("rst_i_data", bus.i_data, 16'h0000);
    chk("rst_d_rdata", bus.d_rdata, 16'h0000);
    chk("rst_led", led, 8'h00);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_no_ready", {bus.i_ready, bus.d_ready}, 2'b00);

    access(2, 16'h0010, 16'hBEEF, "wr10");
    access(0, 16'h0010, 16'h0000, "fetch10");
    access(2, 16'h0000, 16'h1234, "wr0");
    access(2, 16'h0001, 16'h00C3, "wr1");
    access(2, 16'h03FF, 16'h7E57, "wr3ff");
    access(1, 16'h03FF, 16'h0000, "rd3ff");
    access(2, 16'hFFFF, 16'h12A5, "wrled");
    access(1, 16'hFFFF, 16'h0000, "rdled");
    access(0, 16'hFFFF, 16'h0000, "fetchled");
    access(2, 16'h0400, 16'h5555, "wr400");
    access(1, 16'h0400, 16'h0000, "rd400");
    access(1, 16'h0000, 16'h0000, "rd0_alias");
    access(0, 16'h0400, 16'h0000, "fetch400");
    access(3, 16'h0020, 16'h0F0F, "rw20");
    access(1, 16'h0020, 16'h0000, "rd20");

    // Reset during the fetch completion cycle; a write presented with rst is dropped
    bus.i_req = 1'b1; bus.i_addr = 16'h0010;
    @(posedge clk); #1;
    chk("midrst_pre_ready", bus.i_ready, 1'b1);
    rst = 1'b1;
    bus.i_req = 1'b0;
    bus.d_write = 1'b1; bus.d_addr = 16'h0001; bus.d_wdata = 16'h5A5A;
    @(posedge clk); #1;
    bus.d_write = 1'b0;
    chk("midrst_i_ready", bus.i_ready, 1'b0);
    chk("midrst_d_ready", bus.d_ready, 1'b0);
    chk("midrst_i_data", bus.i_data, 16'h0000);
    chk("midrst_led", led, 8'h00);
    rst = 1'b0;
    led_m = 8'h00; i_hold_m = 16'h0; d_hold_m = 16'h0; last_i_m = 1'b1;

    // Both ports held: one grant every second cycle, winner by arbitration rule
    bus.i_req = 1'b1; bus.i_addr = 16'h0010;
    bus.d_read = 1'b1; bus.d_addr = 16'h0020;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (c % 2 == 0) begin
`ifdef SYS_BUS_DPRIO_EN
        win_i = 1'b0;
`else
        win_i = !last_i_m;
`endif
        last_i_m = win_i;
        chk("arb_i_ready", bus.i_ready, win_i);
        chk("arb_d_ready", bus.d_ready, !win_i);
        if (win_i) begin
          chk("arb_i_data", bus.i_data, exp_fetch(16'h0010));
          i_hold_m = exp_fetch(16'h0010);
        end else begin
          chk("arb_d_rdata", bus.d_rdata, exp_read(16'h0020));
          d_hold_m = exp_read(16'h0020);
        end
      end else begin
        chk("arb_gap", {bus.i_ready, bus.d_ready}, 2'b00);
      end
    end
    bus.i_req = 1'b0; bus.d_read = 1'b0;
    @(posedge clk); #1;
    chk("arb_end", {bus.i_ready, bus.d_ready}, 2'b00);

    access(0, 16'h0010, 16'h0000, "postrst_fetch10");
    access(1, 16'h0001, 16'h0000, "postrst_rd1");

    for (int n = 0; n < 60; n++) begin
      k = int'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) a = 16'($urandom_range(16'h0400, 16'hFFFE));
      else a = pool[$urandom_range(0, 9)];
      access(k, a, 16'($urandom), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
`default_nettype wire
